// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the data memory.
//
// Handshake: a requester raises *_req with a stable payload and keeps both
// unchanged until it observes *_gnt high in the same cycle; the transfer
// happens on that clock edge. Read data returns exactly one cycle later,
// qualified by *_rvalid; *_rd_data is meaningless while *_rvalid is low.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    // boot flash loader (writes only)
    logic             flash_req;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    logic             flash_done;
    logic             flash_gnt;
    // CPU data port
    logic             d_req;
    logic             d_wren;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wr_data;
    logic [2:0]       d_funct3;
    logic             d_gnt;
    logic             d_rvalid;
    logic [WIDTH-1:0] d_rd_data;
    // CPU instruction-fetch port (reads only)
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic             i_gnt;
    logic             i_rvalid;
    logic [WIDTH-1:0] i_rd_data;
    // single-port memory
    logic [WIDTH-1:0] mem_addr;
    logic             mem_wren;
    logic [WIDTH-1:0] mem_wr_data;
    logic [2:0]       mem_funct3;
    logic [WIDTH-1:0] mem_rd_data;

    // arbiter view
    modport slave (
        input  flash_req, flash_addr, flash_data, flash_done,
        output flash_gnt,
        input  d_req, d_wren, d_addr, d_wr_data, d_funct3,
        output d_gnt, d_rvalid, d_rd_data,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rd_data,
        output mem_addr, mem_wren, mem_wr_data, mem_funct3,
        input  mem_rd_data
    );

    // requester / memory-side view
    modport master (
        output flash_req, flash_addr, flash_data, flash_done,
        input  flash_gnt,
        output d_req, d_wren, d_addr, d_wr_data, d_funct3,
        input  d_gnt, d_rvalid, d_rd_data,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rd_data,
        input  mem_addr, mem_wren, mem_wr_data, mem_funct3,
        output mem_rd_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the boot loader, the CPU data
// port and the CPU fetch port. CPU ports are locked out until the loader
// signals completion; afterwards data beats fetch unless fetch has been
// denied STARVE_MAX cycles in a row. The loader always wins, so a re-flash
// can happen while the core stalls.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4    // 1..15
) (
    input  logic         clk,
    input  logic         rst,             // asynchronous, active low
    mem_arbiter_if.slave bus,
    output logic         cpu_run,
    output logic         dbg_run,         // FSM state: 1 = RUN, 0 = BOOT
    output logic [3:0]   dbg_starve_cnt
);
    localparam logic [2:0] FUNCT3_WORD = 3'b010;
    localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             cpu_run_q, cpu_run_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             tag_valid_q, tag_valid_d;
    logic             tag_fetch_q, tag_fetch_d;   // owner of the pending read

    logic             run;
    logic             force_fetch;
    logic             flash_gnt, d_gnt, i_gnt;
    logic [WIDTH-1:0] mem_addr, mem_wr_data;
    logic             mem_wren;
    logic [2:0]       mem_funct3;

    assign run = (state_q == ST_RUN);

    // Fixed priority: flash > starved fetch > data > fetch; CPU ports only in RUN.
    // The starvation override fires only at exactly the threshold; a long
    // re-flash can push the count past it, and fetch then waits for a data gap.
    always_comb begin
        flash_gnt   = 1'b0;
        d_gnt       = 1'b0;
        i_gnt       = 1'b0;
        force_fetch = run && bus.i_req && (starve_cnt_q == STARVE_LIM);
        if (bus.flash_req) begin
            flash_gnt = 1'b1;
        end else if (run) begin
            if (force_fetch) begin
                i_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end else if (bus.i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Memory port mux; when idle the data-port payload is parked on the bus.
    always_comb begin
        mem_addr    = bus.d_addr;
        mem_wr_data = bus.d_wr_data;
        mem_funct3  = bus.d_funct3;
        mem_wren    = 1'b0;
        if (flash_gnt) begin
            mem_addr    = bus.flash_addr;
            mem_wr_data = bus.flash_data;
            mem_funct3  = FUNCT3_WORD;
            mem_wren    = 1'b1;
        end else if (d_gnt) begin
            mem_wren    = bus.d_wren;
        end else if (i_gnt) begin
            mem_addr    = bus.i_addr;
            mem_funct3  = FUNCT3_WORD;
        end
    end

    // Next-state: boot/run FSM, fetch starvation counter and read-return tag.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && bus.flash_done) begin
            state_d = ST_RUN;
        end
        cpu_run_d = (state_d == ST_RUN);

        starve_cnt_d = starve_cnt_q;
        if (!run || !bus.i_req || i_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        tag_valid_d = (d_gnt && !bus.d_wren) || i_gnt;
        tag_fetch_d = i_gnt;
    end

    // All state registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            cpu_run_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
            tag_valid_q  <= 1'b0;
            tag_fetch_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_run_q    <= cpu_run_d;
            starve_cnt_q <= starve_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_fetch_q  <= tag_fetch_d;
        end
    end

    assign bus.flash_gnt   = flash_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.i_gnt       = i_gnt;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wren    = mem_wren;
    assign bus.mem_wr_data = mem_wr_data;
    assign bus.mem_funct3  = mem_funct3;
    assign bus.d_rvalid    = tag_valid_q && !tag_fetch_q;
    assign bus.i_rvalid    = tag_valid_q && tag_fetch_q;
    assign bus.d_rd_data   = bus.mem_rd_data;
    assign bus.i_rd_data   = bus.mem_rd_data;

    assign cpu_run        = cpu_run_q;
    assign dbg_run        = run;
    assign dbg_starve_cnt = starve_cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed boot/run scenarios followed by random
// traffic, all checked against a cycle-level reference model of the
// arbitration rules and a shadow copy of memory contents.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int SM = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_run;
    logic       dbg_run;
    logic [3:0] dbg_starve_cnt;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W)) mif ();

    mem_arbiter #(.WIDTH(W), .STARVE_MAX(SM)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (mif),
        .cpu_run        (cpu_run),
        .dbg_run        (dbg_run),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- memory with one-cycle read latency ----------------
    logic [W-1:0] tb_mem [64] = '{default: '0};
    logic [W-1:0] mem_q = '0;

    always @(posedge clk) begin
        if (mif.mem_wren) tb_mem[mif.mem_addr[7:2]] <= mif.mem_wr_data;
        mem_q <= tb_mem[mif.mem_addr[7:2]];
    end
    assign mif.mem_rd_data = mem_q;

    // ---------------- reference model state ----------------
    bit           m_run;
    int           m_starve;
    logic [W-1:0] ref_mem [64];
    logic [W-1:0] exp_q[$];      // expected read data, oldest first
    bit           own_q[$];      // 1 = fetch port owns the read
    bit           g_f, g_d, g_i; // grants expected in the last step
    logic         s_f_gnt, s_d_gnt, s_i_gnt, s_d_rvalid, s_i_rvalid, s_cpu_run, s_run;
    logic [W-1:0] s_d_rd, s_i_rd;
    logic [3:0]   s_starve;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [W-1:0] a);
        return int'(a[7:2]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        mif.flash_req  = 1'b0;
        mif.flash_addr = '0;
        mif.flash_data = '0;
        mif.flash_done = 1'b0;
        mif.d_req      = 1'b0;
        mif.d_wren     = 1'b0;
        mif.d_addr     = '0;
        mif.d_wr_data  = '0;
        mif.d_funct3   = 3'b010;
        mif.i_req      = 1'b0;
        mif.i_addr     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("rst_cpu_run",   W'(cpu_run),        '0);
        chk("rst_state",     W'(dbg_run),        '0);
        chk("rst_starve",    W'(dbg_starve_cnt), '0);
        chk("rst_d_rvalid",  W'(mif.d_rvalid),   '0);
        chk("rst_i_rvalid",  W'(mif.i_rvalid),   '0);
        chk("rst_gnts",      W'({mif.flash_gnt, mif.d_gnt, mif.i_gnt}), '0);
        chk("rst_mem_wren",  W'(mif.mem_wren),   '0);
        exp_q.delete();
        own_q.delete();
        m_run    = 1'b0;
        m_starve = 0;
        g_f = 1'b0; g_d = 1'b0; g_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: inputs are already set (called at the falling edge).
    task automatic step();
        bit           ef, ed, ei, chk_wd, eown;
        logic         ewren;
        logic [W-1:0] eaddr, ewd, edata;
        logic [2:0]   ef3;
        #1;
        ef = 1'b0; ed = 1'b0; ei = 1'b0;
        if (mif.flash_req) ef = 1'b1;
        else if (m_run) begin
            if (mif.i_req && m_starve == SM) ei = 1'b1;
            else if (mif.d_req)              ed = 1'b1;
            else if (mif.i_req)              ei = 1'b1;
        end
        chk("flash_gnt", W'(mif.flash_gnt), W'(ef));
        chk("d_gnt",     W'(mif.d_gnt),     W'(ed));
        chk("i_gnt",     W'(mif.i_gnt),     W'(ei));

        chk_wd = 1'b1;
        if (ef) begin
            ewren = 1'b1; eaddr = mif.flash_addr; ewd = mif.flash_data; ef3 = 3'b010;
        end else if (ed) begin
            ewren = mif.d_wren; eaddr = mif.d_addr; ewd = mif.d_wr_data; ef3 = mif.d_funct3;
        end else if (ei) begin
            ewren = 1'b0; eaddr = mif.i_addr; ewd = '0; ef3 = 3'b010; chk_wd = 1'b0;
        end else begin
            ewren = 1'b0; eaddr = mif.d_addr; ewd = mif.d_wr_data; ef3 = mif.d_funct3;
        end
        chk("mem_wren",   W'(mif.mem_wren),   W'(ewren));
        chk("mem_addr",   mif.mem_addr,       eaddr);
        chk("mem_funct3", W'(mif.mem_funct3), W'(ef3));
        if (chk_wd) chk("mem_wr_data", mif.mem_wr_data, ewd);

        chk("cpu_run", W'(cpu_run),        W'(m_run));
        chk("state",   W'(dbg_run),        W'(m_run));
        chk("starve",  W'(dbg_starve_cnt), W'(m_starve));

        if (exp_q.size() != 0) begin
            edata = exp_q.pop_front();
            eown  = own_q.pop_front();
            chk("d_rvalid", W'(mif.d_rvalid), W'(!eown));
            chk("i_rvalid", W'(mif.i_rvalid), W'(eown));
            if (eown) chk("i_rd_data", mif.i_rd_data, edata);
            else      chk("d_rd_data", mif.d_rd_data, edata);
        end else begin
            chk("d_rvalid_idle", W'(mif.d_rvalid), '0);
            chk("i_rvalid_idle", W'(mif.i_rvalid), '0);
        end

        s_f_gnt = mif.flash_gnt; s_d_gnt = mif.d_gnt; s_i_gnt = mif.i_gnt;
        s_d_rvalid = mif.d_rvalid; s_i_rvalid = mif.i_rvalid;
        s_d_rd = mif.d_rd_data; s_i_rd = mif.i_rd_data;
        s_cpu_run = cpu_run; s_run = dbg_run; s_starve = dbg_starve_cnt;
        g_f = ef; g_d = ed; g_i = ei;

        @(posedge clk);
        if (ed && !mif.d_wren) begin
            exp_q.push_back(ref_mem[widx(mif.d_addr)]); own_q.push_back(1'b0);
        end
        if (ei) begin
            exp_q.push_back(ref_mem[widx(mif.i_addr)]); own_q.push_back(1'b1);
        end
        if (ef) ref_mem[widx(mif.flash_addr)] = mif.flash_data;
        if (ed && mif.d_wren) ref_mem[widx(mif.d_addr)] = mif.d_wr_data;
        if (m_run && mif.i_req && !ei) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else m_starve = 0;
        if (!m_run && mif.flash_done) m_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic random_phase(input int n);
        for (int c = 0; c < n; c++) begin
            if (!mif.flash_req || g_f) begin
                mif.flash_req  = ($urandom_range(0, 9) == 0);
                mif.flash_addr = W'($urandom_range(0, 63)) << 2;
                mif.flash_data = $urandom;
            end
            if (!mif.d_req || g_d) begin
                mif.d_req     = ($urandom_range(0, 9) < 6);
                mif.d_wren    = $urandom_range(0, 1) == 1;
                mif.d_addr    = W'($urandom_range(0, 63)) << 2;
                mif.d_wr_data = $urandom;
                mif.d_funct3  = 3'($urandom_range(0, 7));
            end
            if (!mif.i_req || g_i) begin
                mif.i_req  = ($urandom_range(0, 9) < 6);
                mif.i_addr = W'($urandom_range(0, 63)) << 2;
            end
            mif.flash_done = ($urandom_range(0, 29) == 0);
            step();
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int nd, ni, two, first_i;
        for (int k = 0; k < 64; k++) ref_mem[k] = '0;
        clear_inputs();
        do_reset();

        // boot: loader writes while CPU ports request and are refused
        mif.d_req = 1'b1; mif.i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mif.flash_req  = 1'b1;
            mif.flash_addr = W'(4 * k);
            mif.flash_data = W'(32'h11 * (k + 1));
            step();
            chk("boot_flash_only", W'({s_f_gnt, s_d_gnt, s_i_gnt}), W'(3'b100));
            chk("boot_cpu_run", W'(s_cpu_run), '0);
        end
        mif.flash_req = 1'b0; mif.d_req = 1'b0; mif.i_req = 1'b0;
        mif.flash_done = 1'b1;
        step();
        chk("done_cycle_cpu_run", W'(s_cpu_run), '0);
        mif.flash_done = 1'b0;
        step();
        chk("run_cpu_run", W'(s_cpu_run), W'(1));

        // single fetch of 0x4
        mif.i_req = 1'b1; mif.i_addr = 32'h4;
        step();
        chk("fetch_gnt", W'(s_i_gnt), W'(1));
        mif.i_req = 1'b0;
        step();
        chk("fetch_rvalid", W'(s_i_rvalid), W'(1));
        chk("fetch_data", s_i_rd, 32'h22);
        chk("fetch_no_d_rvalid", W'(s_d_rvalid), '0);

        // store then load on the data port
        mif.d_req = 1'b1; mif.d_wren = 1'b1; mif.d_addr = 32'h8; mif.d_wr_data = 32'hAB;
        step();
        chk("store_gnt", W'(s_d_gnt), W'(1));
        mif.d_wren = 1'b0;
        step();
        chk("load_gnt", W'(s_d_gnt), W'(1));
        chk("store_no_rvalid", W'(s_d_rvalid), '0);
        mif.d_req = 1'b0;
        step();
        chk("load_rvalid", W'(s_d_rvalid), W'(1));
        chk("load_data", s_d_rd, 32'hAB);
        step();
        chk("load_single_rvalid", W'(s_d_rvalid), '0);

        // continuous contention: four data grants then one fetch, repeating
        mif.d_req = 1'b1; mif.d_wren = 1'b0; mif.d_addr = 32'h0;
        mif.i_req = 1'b1; mif.i_addr = 32'h8;
        nd = 0; ni = 0; two = 0; first_i = -1;
        for (int c = 0; c < 15; c++) begin
            step();
            nd += int'(s_d_gnt);
            ni += int'(s_i_gnt);
            if (s_d_gnt && s_i_gnt) two++;
            if (s_i_gnt && first_i < 0) first_i = c;
        end
        chk("starve_d_count", W'(nd), W'(12));
        chk("starve_i_count", W'(ni), W'(3));
        chk("starve_first_i", W'(first_i), W'(SM));
        chk("starve_one_gnt", W'(two), '0);

        // re-flash in RUN beats both CPU ports
        mif.flash_req = 1'b1; mif.flash_addr = 32'hC; mif.flash_data = 32'h44;
        step();
        chk("run_flash_only", W'({s_f_gnt, s_d_gnt, s_i_gnt}), W'(3'b100));
        mif.flash_req = 1'b0; mif.d_req = 1'b0; mif.i_req = 1'b0;
        step();
        chk("run_flash_starve_inc", W'(s_starve), W'(1));

        // reset lands while a fetch read is in flight
        mif.i_req = 1'b1; mif.i_addr = 32'h4;
        #1;
        chk("midrd_i_gnt", W'(mif.i_gnt), W'(1));
        do_reset();
        step();
        chk("midrd_no_rvalid", W'({s_d_rvalid, s_i_rvalid}), '0);
        chk("midrd_boot", W'({s_cpu_run, s_run}), '0);
        step();
        chk("midrd_no_rvalid_late", W'({s_d_rvalid, s_i_rvalid}), '0);

        // random traffic, starting from BOOT, then again after a reset
        random_phase(400);
        do_reset();
        random_phase(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port, one-cycle-read-latency data memory between three requesters: the boot flash loader, the CPU data port and the CPU instruction-fetch port. It holds the CPU ports off until flashing completes, then applies fixed priority (data over instruction) with a starvation guard so instruction fetch always makes progress. Sits between the core/loader and the memory block, driving its address, write-enable, write-data and funct3 inputs and returning its read data.

## Interface
- WIDTH, 32, data/address width of every port
- STARVE_MAX, 4, consecutive denied cycles of instruction fetch before it is forced ahead of data; range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flash_req  in  1  loader write request (writes only)
- flash_addr  in  WIDTH  loader byte address
- flash_data  in  WIDTH  loader write word
- flash_done  in  1  one-cycle pulse: image fully written
- flash_gnt  out  1  loader write accepted this cycle
- d_req  in  1  data-port request
- d_wren  in  1  1 = store, 0 = load
- d_addr  in  WIDTH  data byte address
- d_wr_data  in  WIDTH  store data
- d_funct3  in  3  access size, passed to memory
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rd_data  out  WIDTH  load data
- i_req  in  1  fetch request (reads only)
- i_addr  in  WIDTH  fetch byte address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rd_data  out  WIDTH  fetch data
- mem_addr  out  WIDTH  memory address
- mem_wren  out  1  memory write enable
- mem_wr_data  out  WIDTH  memory write data
- mem_funct3  out  3  memory access size
- mem_rd_data  in  WIDTH  memory q, valid one cycle after a read is presented
- cpu_run  out  1  1 once flashing is complete; core may leave reset/stall

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT. BOOT→RUN on the clock edge that samples flash_done=1. RUN is left only by reset. cpu_run=1 exactly in RUN.
- BOOT: only flash is granted (flash_gnt=flash_req). d_gnt=i_gnt=0 regardless of requests.
- RUN priority: flash > forced-fetch > data > fetch. Forced-fetch holds when starve_cnt==STARVE_MAX and i_req=1.
- starve_cnt: saturating counter, width 4. Increments when i_req=1 and i_gnt=0 in RUN. Clears when i_gnt=1 or i_req=0. Holds at 0 in BOOT.
- At most one gnt is high per cycle. A gnt is combinational from this cycle's req signals and state. A requester holds req and its payload stable until it sees gnt.
- Granted request drives mem_*:
  - flash: mem_wren=1, funct3=WORD (3'b010).
  - data: mem_wren=d_wren, funct3=d_funct3.
  - fetch: mem_wren=0, funct3=WORD.
- No grant: mem_wren=0; mem_addr/mem_wr_data/mem_funct3 are don't-care but stable (hold the data-port values).
- Read routing: a registered tag records {valid, owner} for a granted read (d with d_wren=0, or i). Next cycle the owner's rvalid=1 and its rd_data=mem_rd_data. Writes produce no rvalid.
- d_rd_data and i_rd_data always mirror mem_rd_data; only rvalid qualifies them.
- Back-to-back reads from any mix of ports are accepted every cycle; the tag pipeline is one deep.

## Timing
- Reset (rst=0, async): state=BOOT, cpu_run=0, starve_cnt=0, read tag invalid, d_rvalid=i_rvalid=0, all gnt=0, mem_wren=0.
- Grant latency 0 cycles. Read-data latency exactly 1 cycle after grant. Write takes effect on the grant edge.
- flash_done and flash_req in the same cycle: the write is granted, and RUN starts next cycle.
- Reset mid-read: the pending rvalid is dropped, with no pulse after reset release.
- Flash request in RUN: still highest priority, which allows a re-flash while the CPU stalls.

## Test plan
- Reset, then flash_req for addresses 0x0,0x4,0x8 with data 0x11,0x22,0x33, plus d_req/i_req held high -> only flash_gnt=1 for 3 cycles, mem_wren=1, cpu_run=0; then flash_done pulse -> cpu_run=1 the next cycle.
- RUN: i_req read of 0x4 alone -> i_gnt same cycle, i_rvalid=1 with i_rd_data=0x22 next cycle, d_rvalid=0.
- RUN: d_req store 0xAB to 0x8, then d_req load 0x8 -> two consecutive d_gnt, a single d_rvalid returning 0xAB.
- RUN, STARVE_MAX=4: d_req and i_req held high continuously -> d_gnt for 4 cycles, i_gnt on the 5th, then the pattern repeats; never two gnts in one cycle.
- flash_req, d_req and i_req all high in RUN -> flash_gnt only; starve_cnt increments.
- Read granted, then rst asserted before the next edge -> no rvalid after release, cpu_run=0, state BOOT.
